tdm8_transmitter: RTL

Time-division-multiplexed transmitter for the 8-way data transmission path. It accepts an 8-bit word over a valid/ready handshake and drives it onto a single serial line one bit per slot. It also drives the 3-bit channel select `A`, `B`, `C` that steers the line through the MUX/DMUX link. It replaces hand-driven select stimulus with a sequencer, so a receiving 8-way DMUX reconstructs the word at `oData[{A,B,C}]`.

---
 rtl/tdm8_transmitter.sv | 100 ++++++++++
 1 files changed

// File: rtl/tdm8_transmitter.sv
// tdm8_transmitter: serialises an accepted 8-bit word over 8 TDM slots with a registered slot select.
module tdm8_transmitter #(
    parameter int unsigned SLOT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] iData,
    input  logic       iValid,
    output logic       oReady,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       oLine,
    output logic       oFrame,
    output logic       oBusy,
    output logic       oDone
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(SLOT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] shadow_q, shadow_d;
    logic [2:0] slot_q, slot_d;
    logic [7:0] hold_q, hold_d;
    logic       ready_q, ready_d;
    logic [2:0] sel_q, sel_d;
    logic       line_q, line_d;
    logic       frame_q, frame_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            slot_q   <= '0;
            hold_q   <= '0;
            ready_q  <= 1'b1;
            sel_q    <= '0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            slot_q   <= slot_d;
            hold_q   <= hold_d;
            ready_q  <= ready_d;
            sel_q    <= sel_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        slot_d   = slot_q;
        hold_d   = hold_q;
        case (state_q)
            IDLE: if (iValid && ready_q) begin
                state_d  = SEND;
                shadow_d = iData;
                slot_d   = '0;
                hold_d   = '0;
            end
            SEND: if (hold_q == HOLD_LAST) begin
                hold_d  = '0;
                state_d = slot_q == 3'd7 ? DONE : SEND;
                slot_d  = slot_q == 3'd7 ? slot_q : slot_q + 3'd1;
            end else begin
                hold_d = hold_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so select and line register together on one edge.
    always_comb begin
        ready_d = state_d == IDLE;
        busy_d  = state_d == SEND;
        done_d  = state_d == DONE;
        sel_d   = busy_d ? slot_d : 3'd0;
        line_d  = busy_d && shadow_d[slot_d];
        frame_d = busy_d && slot_d == 3'd0 && hold_d == 8'd0;
    end

    assign oReady = ready_q;
    assign A      = sel_q[2];
    assign B      = sel_q[1];
    assign C      = sel_q[0];
    assign oLine  = line_q;
    assign oFrame = frame_q;
    assign oBusy  = busy_q;
    assign oDone  = done_q;
endmodule
